// File: rtl/pu_arbiter.sv
// Round-robin arbiter sharing one processing_unit among N_REQ requesters.
// Ports: clk/reset, req/req_a/req_b in, gnt/resp_* out, pu_* to/from the unit.
module pu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    pu_start,
  output logic [DATA_W-1:0]       pu_a,
  output logic [DATA_W-1:0]       pu_b,
  output logic                    pu_abort,
  input  logic [DATA_W-1:0]       pu_p,
  input  logic                    pu_ready
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [IW-1:0]       last_grant, last_grant_n;
  logic [WW-1:0]       wd, wd_n;
  logic [N_REQ-1:0]    gnt_n, resp_valid_n;
  logic [DATA_W-1:0]   resp_data_n;
  logic                resp_err_n;
  logic                pu_start_n, pu_abort_n;
  logic [DATA_W-1:0]   pu_a_n, pu_b_n;

  logic                found;
  logic [IW-1:0]       pick;
  int                  cand;
  logic [DATA_W-1:0]   sel_a, sel_b;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IW-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Search starts just after the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick == IW'(j)) begin
        sel_a = req_a[j*DATA_W +: DATA_W];
        sel_b = req_b[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    last_grant_n = last_grant;
    wd_n         = wd;
    gnt_n        = gnt;
    resp_valid_n = '0;
    resp_data_n  = resp_data;
    resp_err_n   = resp_err;
    pu_start_n   = 1'b0;
    pu_abort_n   = 1'b0;
    pu_a_n       = pu_a;
    pu_b_n       = pu_b;
    unique case (state)
      IDLE: begin
        if (found) begin
          idx_n      = pick;
          pu_a_n     = sel_a;
          pu_b_n     = sel_b;
          gnt_n      = onehot(pick);
          pu_start_n = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wd_n = wd + WW'(1);
        // Ready beats the watchdog on the same cycle.
        if (pu_ready) begin
          resp_data_n  = pu_p;
          resp_err_n   = 1'b0;
          resp_valid_n = onehot(idx);
          state_n      = RESP;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          resp_data_n  = '0;
          resp_err_n   = 1'b1;
          pu_abort_n   = 1'b1;
          resp_valid_n = onehot(idx);
          state_n      = RESP;
        end
      end
      RESP: begin
        last_grant_n = idx;
        gnt_n        = '0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= IW'(N_REQ - 1);
      wd         <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      pu_start   <= 1'b0;
      pu_abort   <= 1'b0;
      pu_a       <= '0;
      pu_b       <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      last_grant <= last_grant_n;
      wd         <= wd_n;
      gnt        <= gnt_n;
      resp_valid <= resp_valid_n;
      resp_data  <= resp_data_n;
      resp_err   <= resp_err_n;
      pu_start   <= pu_start_n;
      pu_abort   <= pu_abort_n;
      pu_a       <= pu_a_n;
      pu_b       <= pu_b_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pu_arbiter.sv
// Directed bench for pu_arbiter with a delay-programmable PU model.
// Ports: drives req/operands/pu_ready, checks grant/response/pu outputs.
module tb_pu_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   gnt, resp_valid;
  logic [W-1:0]   resp_data, pu_a, pu_b;
  logic           resp_err, busy, pu_start, pu_abort;
  logic [W-1:0]   pu_p = '0;
  logic           pu_ready;
  logic           mdl_ready = 1'b0;
  logic           stray_ready = 1'b0;
  int             pu_delay = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  assign pu_ready = mdl_ready | stray_ready;

  pu_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy),
    .pu_start(pu_start), .pu_a(pu_a), .pu_b(pu_b),
    .pu_abort(pu_abort), .pu_p(pu_p), .pu_ready(pu_ready)
  );

  always #5 clk = ~clk;

  // PU model: ready pulses pu_delay cycles after pu_start (0 = never).
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      mdl_ready = 1'b0;
      if (!reset) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mdl_ready = 1'b1;
      end
      if (pu_start && pu_delay > 0) cnt = pu_delay;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output logic [N-1:0] rv, output int cyc);
    rv = '0;
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      cyc = c;
      if (resp_valid != '0) begin
        rv = resp_valid;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0;
    step();
    step();
    n_checks++;
    if ({gnt, resp_valid} !== '0) begin
      n_fail++;
      $display("FAIL rst_gnt_rv got %h want 0", {gnt, resp_valid});
    end
    n_checks++;
    if ({resp_data, resp_err, busy, pu_start, pu_abort} !== '0) begin
      n_fail++;
      $display("FAIL rst_ctl got %h want 0",
        {resp_data, resp_err, busy, pu_start, pu_abort});
    end
    n_checks++;
    if ({pu_a, pu_b} !== '0) begin
      n_fail++;
      $display("FAIL rst_ops got %h want 0", {pu_a, pu_b});
    end
  endtask

  task automatic test_single();
    pu_delay = 3;
    pu_p = 16'h4E00;
    req_a[15:0] = 16'h4400;
    req_b[15:0] = 16'h4600;
    reset = 1'b1;
    req = 4'b0001;
    step();
    n_checks++;
    if ({pu_start, pu_a, pu_b, gnt} !== {1'b1, 16'h4400, 16'h4600, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_issue got %h want %h",
        {pu_start, pu_a, pu_b, gnt}, {1'b1, 16'h4400, 16'h4600, 4'b0001});
    end
    step();
    n_checks++;
    if ({pu_start, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_start_pulse got %b want 01", {pu_start, busy});
    end
    step();
    step();
    n_checks++;
    if (resp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_early_rv got %b want 0000", resp_valid);
    end
    step();
    n_checks++;
    if ({resp_valid, resp_data, resp_err} !== {4'b0001, 16'h4E00, 1'b0}) begin
      n_fail++;
      $display("FAIL single_resp got %h want %h",
        {resp_valid, resp_data, resp_err}, {4'b0001, 16'h4E00, 1'b0});
    end
    req = '0;
    step();
    n_checks++;
    if ({busy, resp_valid, gnt} !== '0) begin
      n_fail++;
      $display("FAIL single_idle got %h want 0", {busy, resp_valid, gnt});
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rv;
    logic [N-1:0] exp_rv [5];
    int cyc;
    exp_rv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    pu_delay = 1;
    pu_p = 16'h3C00;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp(rv, cyc);
      n_checks++;
      if (rv !== exp_rv[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got %b want %b", k, rv, exp_rv[k]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_rotation();
    logic [N-1:0] rv;
    int cyc;
    pu_delay = 2;
    req = 4'b0100;
    wait_resp(rv, cyc);
    n_checks++;
    if (rv !== 4'b0100) begin
      n_fail++;
      $display("FAIL rot_first got %b want 0100", rv);
    end
    req = 4'b0101;
    wait_resp(rv, cyc);
    n_checks++;
    if (rv !== 4'b0001) begin
      n_fail++;
      $display("FAIL rot_wrap got %b want 0001", rv);
    end
    req = 4'b0100;
    wait_resp(rv, cyc);
    n_checks++;
    if (rv !== 4'b0100) begin
      n_fail++;
      $display("FAIL rot_second got %b want 0100", rv);
    end
    req = '0;
    step();
  endtask

  task automatic test_timeout();
    logic [N-1:0] rv;
    int cyc;
    int aborts;
    pu_delay = 0;
    pu_p = 16'h1234;
    req = 4'b0010;
    aborts = 0;
    rv = '0;
    cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (pu_abort) aborts++;
      if (resp_valid != '0) begin
        rv = resp_valid;
        cyc = c;
        break;
      end
    end
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL to_latency got %0d want 10", cyc);
    end
    n_checks++;
    if ({rv, resp_err, resp_data, pu_abort} !== {4'b0010, 1'b1, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL to_resp got %h want %h",
        {rv, resp_err, resp_data, pu_abort}, {4'b0010, 1'b1, 16'h0, 1'b1});
    end
    req = '0;
    step();
    if (pu_abort) aborts++;
    n_checks++;
    if (aborts !== 1) begin
      n_fail++;
      $display("FAIL to_abort_count got %0d want 1", aborts);
    end
    pu_delay = 2;
    pu_p = 16'h5A5A;
    req = 4'b0010;
    wait_resp(rv, cyc);
    n_checks++;
    if ({rv, resp_err, resp_data} !== {4'b0010, 1'b0, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL to_recover got %h want %h",
        {rv, resp_err, resp_data}, {4'b0010, 1'b0, 16'h5A5A});
    end
    req = '0;
    step();
  endtask

  task automatic test_collision();
    logic [N-1:0] rv;
    int cyc;
    int aborts;
    pu_delay = 8;
    pu_p = 16'hBEEF;
    req = 4'b0001;
    aborts = 0;
    rv = '0;
    cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (pu_abort) aborts++;
      if (resp_valid != '0) begin
        rv = resp_valid;
        cyc = c;
        break;
      end
    end
    n_checks++;
    if ({rv, resp_err, resp_data} !== {4'b0100 >> 2, 1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL col_resp got %h want %h",
        {rv, resp_err, resp_data}, {4'b0001, 1'b0, 16'hBEEF});
    end
    n_checks++;
    if (cyc !== 10 || aborts !== 0) begin
      n_fail++;
      $display("FAIL col_timing got cyc=%0d aborts=%0d want 10/0", cyc, aborts);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_wait();
    logic [N-1:0] rv;
    int cyc;
    pu_delay = 0;
    req = 4'b1000;
    req_a[63:48] = 16'hAAAA;
    for (int c = 0; c < 4; c++) step();
    n_checks++;
    if ({busy, gnt} !== {1'b1, 4'b1000}) begin
      n_fail++;
      $display("FAIL rw_inwait got %b want 11000", {busy, gnt});
    end
    reset = 1'b0;
    step();
    n_checks++;
    if ({gnt, resp_valid, resp_data, resp_err, busy,
         pu_start, pu_abort, pu_a, pu_b} !== '0) begin
      n_fail++;
      $display("FAIL rw_cleared got %h want 0",
        {gnt, resp_valid, resp_data, resp_err, busy,
         pu_start, pu_abort, pu_a, pu_b});
    end
    reset = 1'b1;
    pu_delay = 1;
    req = 4'b1001;
    wait_resp(rv, cyc);
    n_checks++;
    if (rv !== 4'b0001) begin
      n_fail++;
      $display("FAIL rw_priority got %b want 0001", rv);
    end
    req = '0;
    step();
    step();
    stray_ready = 1'b1;
    pu_p = 16'h7777;
    step();
    stray_ready = 1'b0;
    step();
    n_checks++;
    if ({resp_valid, busy, gnt, pu_start} !== '0) begin
      n_fail++;
      $display("FAIL stray_ready got %h want 0",
        {resp_valid, busy, gnt, pu_start});
    end
    n_checks++;
    if (resp_data === 16'h7777) begin
      n_fail++;
      $display("FAIL stray_data got %h want not 7777", resp_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_timeout();
    test_collision();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
